// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - 8N1-style UART receiver driven by an external mid-bit sample tick
//
// Receives LSB-first frames of DATA_BITS payload bits (legal 5..8) with one
// start bit and one stop bit. The external baud generator is started with
// bps_en and returns one clk_uart tick per bit, placed near mid-bit.
//
// Ports:
//   clk        system clock, shared with the baud tick generator
//   RST        synchronous active-high reset
//   rx         asynchronous serial line, idles high
//   clk_uart   one-cycle bit-sample tick, meaningful only while bps_en=1
//   bps_en     runs the generator's bit counter for the whole frame
//   rx_data    last good received word
//   rx_valid   rx_data holds an unconsumed word
//   rx_ready   consumer takes the word when rx_valid=1
//   frame_err  one-cycle pulse: stop bit sampled low, word discarded
//   overrun    one-cycle pulse: good word dropped, previous word still pending

module uart_rx_core #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 RST,
    input  logic                 rx,
    input  logic                 clk_uart,
    output logic                 bps_en,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    logic [1:0]           state;
    logic [2:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;

    logic                 rx_meta;
    logic                 rx_s;
    logic                 rx_s_d;
    logic [1:0]           sync_fill;
    logic                 line_armed;
    logic                 start_edge;

    // The synchronizer flops reset to 1 so that an idle-high line is quiet
    // after reset. sync_fill tracks when rx_s holds a genuine line sample;
    // line_armed only sets once a real 1 has been observed, so a line that
    // is already low when reset is released cannot fake a start edge.
    always_ff @(posedge clk) begin
        if (RST) begin
            rx_meta    <= 1'b1;
            rx_s       <= 1'b1;
            rx_s_d     <= 1'b1;
            sync_fill  <= 2'b00;
            line_armed <= 1'b0;
        end else begin
            rx_meta   <= rx;
            rx_s      <= rx_meta;
            rx_s_d    <= rx_s;
            sync_fill <= {sync_fill[0], 1'b1};
            if (sync_fill[1] && rx_s) begin
                line_armed <= 1'b1;
            end
        end
    end

    assign start_edge = line_armed && rx_s_d && !rx_s;

    // bps_en is written alongside every state change so it stays high
    // exactly while the state is START, DATA or STOP.
    always_ff @(posedge clk) begin
        if (RST) begin
            state     <= S_IDLE;
            bps_en    <= 1'b0;
            bit_cnt   <= 3'd0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;

            // Consumer handshake; a completing frame below overrides this.
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (start_edge) begin
                        state  <= S_START;
                        bps_en <= 1'b1;
                    end
                end

                S_START: begin
                    if (clk_uart) begin
                        if (!rx_s) begin
                            state   <= S_DATA;
                            bit_cnt <= 3'd0;
                        end else begin
                            // Start bit gone high by mid-bit: treat as a glitch.
                            state  <= S_IDLE;
                            bps_en <= 1'b0;
                        end
                    end
                end

                S_DATA: begin
                    if (clk_uart) begin
                        if (DATA_BITS > 1) begin
                            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                        end else begin
                            shreg <= rx_s;
                        end
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == LAST_BIT) begin
                            state <= S_STOP;
                        end
                    end
                end

                S_STOP: begin
                    if (clk_uart) begin
                        state  <= S_IDLE;
                        bps_en <= 1'b0;
                        if (rx_s) begin
                            // A word being consumed this cycle frees the slot.
                            if (!rx_valid || rx_ready) begin
                                rx_data  <= shreg;
                                rx_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                end

                default: begin
                    state  <= S_IDLE;
                    bps_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - randomized self-checking bench for uart_rx_core

module tb_uart_rx_core;

    localparam int BPS = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, rx, rx_ready, rx5, rx_ready5;
    logic       bps_en, clk_uart, rx_valid, frame_err, overrun;
    logic [7:0] rx_data;
    logic       bps_en5, clk_uart5, rx_valid5, frame_err5, overrun5;
    logic [4:0] rx_data5;

    uart_rx_core #(.DATA_BITS(8)) dut8 (
        .clk(clk), .RST(rst), .rx(rx), .clk_uart(clk_uart), .bps_en(bps_en),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .frame_err(frame_err), .overrun(overrun)
    );

    uart_rx_core #(.DATA_BITS(5)) dut5 (
        .clk(clk), .RST(rst), .rx(rx5), .clk_uart(clk_uart5), .bps_en(bps_en5),
        .rx_data(rx_data5), .rx_valid(rx_valid5), .rx_ready(rx_ready5),
        .frame_err(frame_err5), .overrun(overrun5)
    );

    // Baud generator model: counter cleared while disabled, tick at mid-bit.
    int cnt = 0, cnt5 = 0, tk = 0;
    always @(posedge clk) begin
        cnt  <= !bps_en  ? 0 : (cnt  == BPS - 1 ? 0 : cnt  + 1);
        cnt5 <= !bps_en5 ? 0 : (cnt5 == BPS - 1 ? 0 : cnt5 + 1);
        tk   <= !bps_en  ? 0 : (clk_uart ? tk + 1 : tk);
    end
    assign clk_uart  = bps_en  && (cnt  == BPS / 2);
    assign clk_uart5 = bps_en5 && (cnt5 == BPS / 2);

    // Output monitors
    int   fe_cyc = 0, fe_pulse = 0, ov_cnt = 0, vrise = 0, bps_seen = 0;
    int   tick5 = 0, err5 = 0;
    logic fe_q = 1'b0, v_q = 1'b0;
    int   acc_q[$];
    int   acc5[$];
    always @(negedge clk) begin
        if (frame_err) fe_cyc++;
        if (frame_err && !fe_q) fe_pulse++;
        fe_q = frame_err;
        if (overrun) ov_cnt++;
        if (rx_valid && !v_q) vrise++;
        v_q = rx_valid;
        if (rx_valid && rx_ready) acc_q.push_back(int'(rx_data));
        if (bps_en) bps_seen++;
        if (clk_uart5) tick5++;
        if (rx_valid5 && rx_ready5) acc5.push_back(int'(rx_data5));
        if (frame_err5 || overrun5) err5++;
    end

    int n_chk = 0, n_pass = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drive(input bit sel, input bit v, input int n);
        if (sel) rx5 = v; else rx = v;
        idle(n);
    endtask

    // Serial frame, LSB first; the line is left high afterwards.
    task automatic send(input bit sel, input int nbits, input int data, input bit stop_ok);
        drive(sel, 1'b0, BPS);
        for (int i = 0; i < nbits; i++) drive(sel, data[i], BPS);
        drive(sel, stop_ok, BPS);
        if (sel) rx5 = 1'b1; else rx = 1'b1;
    endtask

    task automatic clear_mon();
        fe_cyc = 0; fe_pulse = 0; ov_cnt = 0; vrise = 0; bps_seen = 0;
        acc_q.delete();
    endtask

    int exp_q[$];
    int last_good, exp_fe, d, gap;
    bit stop_ok, prev_bad, hit;

    initial begin
        rst = 1'b1; rx = 1'b1; rx5 = 1'b1; rx_ready = 1'b1; rx_ready5 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_bps_en", bps_en, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        rst = 1'b0;
        idle(5);

        // Back-to-back frames, no idle gap
        clear_mon();
        send(0, 8, 8'h55, 1);
        send(0, 8, 8'hA3, 1);
        idle(6);
        check("b2b_count", acc_q.size(), 2);
        check("b2b_word0", acc_q.size() > 0 ? acc_q[0] : -1, 8'h55);
        check("b2b_word1", acc_q.size() > 1 ? acc_q[1] : -1, 8'hA3);
        check("b2b_vrise", vrise, 2);
        check("b2b_no_err", fe_cyc + ov_cnt, 0);

        // Short start glitch, then a real frame
        clear_mon();
        drive(0, 1'b0, 4);
        rx = 1'b1;
        idle(40);
        check("glitch_bps_pulsed", int'(bps_seen > 0 && bps_seen < BPS), 1);
        check("glitch_bps_low", bps_en, 0);
        check("glitch_quiet", vrise + fe_cyc + ov_cnt, 0);
        send(0, 8, 8'h3C, 1);
        idle(6);
        check("glitch_next_word", acc_q.size() == 1 ? acc_q[0] : -1, 8'h3C);
        last_good = 8'h3C;

        // Bad stop bit
        clear_mon();
        send(0, 8, 8'hF0, 0);
        idle(20);
        check("ferr_cycles", fe_cyc, 1);
        check("ferr_pulses", fe_pulse, 1);
        check("ferr_no_valid", vrise, 0);
        check("ferr_data_kept", rx_data, last_good);

        // Break: line held low for many frame times
        clear_mon();
        drive(0, 1'b0, BPS * 30);
        rx = 1'b1;
        idle(40);
        check("break_one_ferr", fe_pulse, 1);
        check("break_no_valid", vrise, 0);

        // Overrun with the consumer stalled
        clear_mon();
        rx_ready = 1'b0;
        send(0, 8, 8'h11, 1);
        idle(4);
        send(0, 8, 8'h22, 1);
        idle(4);
        check("ovr_data_held", rx_data, 8'h11);
        check("ovr_valid_held", rx_valid, 1);
        check("ovr_pulse", ov_cnt, 1);
        hit = 1'b0;
        fork
            send(0, 8, 8'h33, 1);
            begin
                for (int c = 0; c < 600 && !hit; c++) begin
                    @(posedge clk); #1;
                    if (clk_uart && tk == 9) begin
                        rx_ready = 1'b1;
                        @(posedge clk); #1;
                        rx_ready = 1'b0;
                        hit = 1'b1;
                    end
                end
            end
        join
        check("ovr_stop_tick_seen", hit, 1);
        idle(4);
        check("ovr_replace_data", rx_data, 8'h33);
        check("ovr_replace_valid", rx_valid, 1);
        check("ovr_no_new_pulse", ov_cnt, 1);
        rx_ready = 1'b1;
        idle(4);

        // Reset in the middle of data bit 4
        clear_mon();
        hit = 1'b0;
        fork
            send(0, 8, 8'hF0 | int'($urandom_range(0, 15)), 1);
            begin
                for (int c = 0; c < 600 && !hit; c++) begin
                    @(posedge clk); #1;
                    if (bps_en && tk == 5) begin
                        rst = 1'b1;
                        @(posedge clk); #1;
                        rst = 1'b0;
                        hit = 1'b1;
                        check("midrst_bps_en", bps_en, 0);
                        check("midrst_rx_valid", rx_valid, 0);
                        check("midrst_rx_data", rx_data, 0);
                        check("midrst_errs", frame_err + overrun, 0);
                    end
                end
            end
        join
        check("midrst_seen", hit, 1);
        idle(40);
        check("midrst_no_word", vrise + fe_cyc, 0);
        send(0, 8, 8'h7E, 1);
        idle(6);
        check("midrst_next_word", acc_q.size() == 1 ? acc_q[0] : -1, 8'h7E);

        // Line low across reset release must not start a frame
        rx = 1'b0; rst = 1'b1;
        idle(2);
        rst = 1'b0;
        bps_seen = 0;
        idle(60);
        check("low_after_rst_quiet", bps_seen, 0);
        rx = 1'b1;
        idle(10);

        // Randomized frames against the queue model
        clear_mon();
        exp_q.delete();
        exp_fe = 0;
        prev_bad = 1'b0;
        for (int n = 0; n < 12; n++) begin
            d = int'($urandom_range(0, 255));
            stop_ok = ($urandom_range(0, 5) != 0);
            gap = prev_bad ? int'($urandom_range(2, 20)) : int'($urandom_range(0, 20));
            idle(gap);
            send(0, 8, d, stop_ok);
            if (stop_ok) exp_q.push_back(d); else exp_fe++;
            prev_bad = !stop_ok;
        end
        idle(20);
        check("rand_count", acc_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("rand_word%0d", i), i < acc_q.size() ? acc_q[i] : -1, exp_q[i]);
        check("rand_ferr", fe_pulse, exp_fe);
        check("rand_overrun", ov_cnt, 0);

        // Five-bit payload instance
        tick5 = 0;
        acc5.delete();
        send(1, 5, 5'h15, 1);
        idle(8);
        check("db5_word", acc5.size() == 1 ? acc5[0] : -1, 5'h15);
        check("db5_ticks", tick5, 7);
        check("db5_bps_low", bps_en5, 0);
        acc5.delete();
        exp_q.delete();
        for (int n = 0; n < 3; n++) begin
            d = int'($urandom_range(0, 31));
            send(1, 5, d, 1);
            exp_q.push_back(d);
        end
        idle(8);
        check("db5_rand_count", acc5.size(), 3);
        for (int i = 0; i < 3; i++)
            check($sformatf("db5_rand%0d", i), i < acc5.size() ? acc5[i] : -1, exp_q[i]);
        check("db5_no_err", err5, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- 8N1-style UART receiver that pairs with the team's baud tick generator (clkuart_pwm).
- Asserts bps_en to start the generator on a detected start edge. Samples rx on each generator tick; ticks fall at mid-bit.
- Presents received words through a valid/ready handshake to the APB/AHB UART wrapper on the Cortex-M0 bus.
- Reports framing and overrun errors as one-cycle pulses.

Parameters:
DATA_BITS, 8, payload bits per frame, LSB first, legal range 5..8.

Ports:
clk  input  1  system clock; same clock as the tick generator.
RST  input  1  synchronous active-high reset.
rx  input  1  asynchronous serial line; idles high.
clk_uart  input  1  one-cycle bit-sample tick from the generator; meaningful only while bps_en=1.
bps_en  output  1  enables the generator's bit counter; high for a whole frame.
rx_data  output  DATA_BITS  last good received word.
rx_valid  output  1  rx_data holds an unconsumed word.
rx_ready  input  1  consumer accepts the word when rx_valid=1.
frame_err  output  1  one-cycle pulse: stop bit sampled low.
overrun  output  1  one-cycle pulse: good word dropped because rx_valid was still pending.

Behaviour:
- One clock domain. Reset is synchronous and active-high (RST), sampled on the rising edge of clk.
- Reset values:
  - bps_en=0, rx_data=0, rx_valid=0, frame_err=0, overrun=0.
  - State=IDLE, bit counter=0, shift register=0.
  - Both synchronizer flops=1, edge-history flop=1.
- Input conditioning:
  - rx passes through a 2-flop synchronizer to give rx_s.
  - rx_s_d is rx_s delayed by one cycle.
  - A start edge is rx_s_d=1 and rx_s=0.
- State machine IDLE/START/DATA/STOP:
  - bps_en is registered. It is 1 exactly while the state is START, DATA or STOP.
  - IDLE: on a start edge -> START.
  - START, on clk_uart: if rx_s=0 -> DATA with bit counter=0. If rx_s=1 (glitch) -> IDLE, with no outputs touched.
  - DATA, on clk_uart: shift reg <= {rx_s, shreg[DATA_BITS-1:1]} (LSB first), and bit counter increments. On the tick that captures bit DATA_BITS-1 -> STOP.
  - STOP, on clk_uart: if rx_s=1 this is a good frame; otherwise frame_err pulses for 1 cycle and the word is discarded. Either way -> IDLE.
  - Ticks that arrive while in IDLE are ignored.
- Return to IDLE and back-to-back frames:
  - Returning to IDLE drops bps_en. The generator counter then clears, so the next frame restarts the bit phase from its own edge.
  - A start edge that occurs in the first IDLE cycle is accepted.
  - Back-to-back frames with zero idle time between stop bit and next start bit must be received.
- Handshake on a good frame (all changes take effect the cycle after the STOP tick):
  - rx_valid=0: load rx_data and set rx_valid=1.
  - rx_valid=1 and rx_ready=1 in the same cycle: load rx_data. rx_valid stays 1 and there is no overrun.
  - rx_valid=1 and rx_ready=0: keep the old rx_data, leave rx_valid=1, pulse overrun.
- Handshake when no frame completes: rx_valid&rx_ready clears rx_valid next cycle. rx_data holds its value.
- Latency: rx_valid rises 1 clk after the STOP-bit tick, about (DATA_BITS+1.5) bit times after the start edge plus 3 clk for synchronizer, edge detect and bps_en registration.
- Reset mid-frame: everything returns to reset values on the next edge and the partial word is lost. After RST deasserts, a line held low does not produce a start edge until a 1 is seen.
- A line held low (break) produces at most one frame_err. The block then waits in IDLE for a rising and falling edge.

Test Plan:
1. Generator BPS_PARA=16, send 0x55 then 0xA3 with no idle gap, rx_ready=1 -> rx_valid pulses twice with rx_data=0x55 then 0xA3; frame_err=0 and overrun=0 throughout.
2. rx low for 4 clk (shorter than half a bit) then high -> bps_en rises then falls after the START tick; rx_valid, frame_err and overrun stay 0; a following valid 0x3C frame is received correctly.
3. Send 0xF0 with the stop bit driven 0 -> frame_err pulses for exactly 1 cycle; rx_valid stays 0; rx_data keeps its prior value.
4. rx_ready=0, send 0x11 then 0x22 -> rx_data=0x11 and rx_valid=1 held, overrun pulses once for the second frame. Then set rx_ready=1 on the cycle the third frame 0x33 completes -> rx_data=0x33, rx_valid stays 1, no overrun.
5. Assert RST during data bit 4 of a frame -> next cycle bps_en=0 and all outputs at reset values. The frame remainder does not produce rx_valid; a later 0x7E frame is received.
6. DATA_BITS=5, send 0x15 -> rx_data=5'h15; bps_en covers exactly 7 ticks (start, 5 data bits, stop).
